// File: rtl/uart_rx_core.sv
// Purpose: UART receiver. Synchronises rx, samples each bit at mid-bit and deserialises LSB-first.
// Latency: valid rises 1 clk after the mid-point of the last stop bit, plus SYNC_STAGES clk of input delay.
// Backpressure: holds one word on valid/ready; a good word that completes while valid & !ready is dropped and overrun pulses.
//
// Ports:
//   clk, rst_n            system clock (posedge), asynchronous active-low reset
//   rx                    serial line, idle high, asynchronous to clk
//   data/valid/ready      received word and its handshake (data stable while valid=1)
//   busy                  receiver is inside a frame (FSM not idle)
//   frame_err             1-cycle pulse: a sampled stop bit was 0
//   parity_err            1-cycle pulse: parity mismatch (always 0 unless UART_RX_PARITY_EN)
//   overrun               1-cycle pulse: good word completed while valid & !ready
//
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit between data and stop bits;
// PARITY_ODD selects odd (1) or even (0) parity when it is defined.

module uart_rx_core #(
    parameter int CYCLES_PER_BIT = 10416,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int PARITY_ODD     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW   = $clog2(CYCLES_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int HALF = CYCLES_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    // Out-of-range parameters stop elaboration rather than build a broken receiver.
    if (CYCLES_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_core: parameter out of range");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    state_t                 state_q,    state_d;
    logic [CW-1:0]          cnt_q,      cnt_d;
    logic [BW-1:0]          bit_idx_q,  bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]   shreg_q,    shreg_d;
    logic                   stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0]   data_q,     data_d;
    logic                   valid_q,    valid_d;
    logic                   frame_err_q,  frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q,    overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q,  par_bad_d;
    logic                   par_exp;
`endif

    logic          rx_s;
    logic [CW-1:0] cnt_inc;
    logic          word_done;
    logic          frame_bad;
    logic          par_bad;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    // Free-running bit-period counter wraps at the end of each bit period.
    assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], rx};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shreg_d      = shreg_q;
        stop_bad_d   = stop_bad_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        word_done    = 1'b0;
        frame_bad    = 1'b0;
        par_bad      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        par_exp      = (PARITY_ODD != 0) ? ~^shreg_q : ^shreg_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_d  = 1'b0;
`endif
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_MID) begin
                    if (rx_s) begin
                        // Line went back high before mid-start: glitch, ignore silently.
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end
                end
            end

            S_DATA: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_LAST) begin
                    // Shift in from the top so the first bit ends up in bit 0.
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d    = S_PARITY;
`else
                        state_d    = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_LAST) begin
                    par_bad_d = (rx_s != par_exp);
                    state_d   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_LAST) begin
                    stop_bad_d = stop_bad_q | ~rx_s;
                    if (stop_idx_q == STOP_LAST) begin
                        // Return to idle at mid-stop so the next start edge is caught early.
                        word_done = 1'b1;
                        frame_bad = stop_bad_q | ~rx_s;
                        state_d   = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef UART_RX_PARITY_EN
        par_bad = par_bad_q;
`endif

        // Consumer handshake; a good word completing on the same edge overrides below.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (word_done) begin
            frame_err_d  = frame_bad;
            parity_err_d = par_bad;
            if (!frame_bad && !par_bad) begin
                if (!valid_q || ready) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end else begin
                    // Held word still unconsumed: keep it and drop the new one.
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shreg_q      <= '0;
            stop_bad_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shreg_q      <= shreg_d;
            stop_bad_q   <= stop_bad_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clk/bit, 8 data bits, 1 stop bit.
// Expected values are hand-derived from the frame timing and bit patterns.
// A negedge monitor counts output pulses; each test compares count deltas.

module tb_uart_rx_core;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int DONE_OFS = 171;  // edges from start-bit drive to completion edge
`else
    localparam int DONE_OFS = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int start_cyc = 0;
    int valid_cycles = 0;
    int valid_rise_cyc = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    int busy_cnt = 0;
    logic valid_prev = 1'b0;

    uart_rx_core #(
        .CYCLES_PER_BIT(CPB),
        .DATA_BITS     (8),
        .STOP_BITS     (1),
        .SYNC_STAGES   (2),
        .PARITY_ODD    (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cycles = valid_cycles + 1;
        if (valid === 1'b1 && valid_prev !== 1'b1) valid_rise_cyc = cyc;
        valid_prev = valid;
        if (frame_err === 1'b1)  fe_cnt = fe_cnt + 1;
        if (parity_err === 1'b1) pe_cnt = pe_cnt + 1;
        if (overrun === 1'b1)    ov_cnt = ov_cnt + 1;
        if (busy === 1'b1)       busy_cnt = busy_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par !== par) rx = 1'b1;  // parity bit not transmitted in this build
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (data !== 8'h00)      begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic_frame;
        int v0, f0, p0, o0;
        v0 = valid_cycles; f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data); end
        checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL basic_valid_len: got %0d expected 1", valid_cycles - v0); end
        checks++; if (valid_rise_cyc - start_cyc !== DONE_OFS) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", valid_rise_cyc - start_cyc, DONE_OFS); end
        checks++; if (fe_cnt - f0 !== 0 || pe_cnt - p0 !== 0 || ov_cnt - o0 !== 0) begin errors++; $display("FAIL basic_flags: got fe=%0d pe=%0d ov=%0d expected 0", fe_cnt - f0, pe_cnt - p0, ov_cnt - o0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_glitch;
        int v0, f0, b0;
        v0 = valid_cycles; f0 = fe_cnt; b0 = busy_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        idle(30);
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - f0); end
        checks++; if (busy_cnt - b0 !== CPB / 2) begin errors++; $display("FAIL glitch_busy_len: got %0d expected %0d", busy_cnt - b0, CPB / 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_frame_error;
        int v0, f0, p0;
        v0 = valid_cycles; f0 = fe_cnt; p0 = pe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(40);
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - f0); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h expected a5", data); end
        checks++; if (pe_cnt - p0 !== 0) begin errors++; $display("FAIL ferr_parity: got %0d expected 0", pe_cnt - p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ov_cnt;
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        idle(10);
        checks++; if (valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL ovr_first: got valid=%b data=%h expected 1/11", valid, data); end
        send_frame(8'h22, 1'b0, 1'b1);
        idle(10);
        checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - o0); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h expected 11", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", valid); end
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", valid); end
        ready = 1'b1;
        idle(5);
    endtask

    task automatic test_back_to_back;
        int o0;
        o0 = ov_cnt;
        ready = 1'b0;
        send_frame(8'h44, 1'b0, 1'b1);
        idle(10);
        checks++; if (valid !== 1'b1 || data !== 8'h44) begin errors++; $display("FAIL b2b_first: got valid=%b data=%h expected 1/44", valid, data); end
        fork
            send_frame(8'h33, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (DONE_OFS - 1) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        idle(10);
        checks++; if (data !== 8'h33) begin errors++; $display("FAIL b2b_reload_data: got %h expected 33", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_stays: got %b expected 1", valid); end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_no_overrun: got %0d expected 0", ov_cnt - o0); end
        ready = 1'b1;
        idle(3);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", valid); end
    endtask

    task automatic test_break;
        int v0, f0;
        v0 = valid_cycles; f0 = fe_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (2 * DONE_OFS) @(posedge clk);
        #1 rx = 1'b1;
        idle(40);
        checks++; if (fe_cnt - f0 !== 2) begin errors++; $display("FAIL break_frame_errs: got %0d expected 2", fe_cnt - f0); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL break_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, f0;
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_state: got busy=%b valid=%b expected 0/0", busy, valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {frame_err, parity_err, overrun}); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after: got %b expected 0", busy); end
        v0 = valid_cycles; f0 = fe_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(20);
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h expected 5a", data); end
        checks++; if (valid_cycles - v0 !== 1 || fe_cnt - f0 !== 0) begin errors++; $display("FAIL rstmid_next_flags: got valid=%0d fe=%0d expected 1/0", valid_cycles - v0, fe_cnt - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, p0;
        v0 = valid_cycles; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        checks++; if (data !== 8'h07 || valid_cycles - v0 !== 1) begin errors++; $display("FAIL parity_good: got data=%h valid=%0d expected 07/1", data, valid_cycles - v0); end
        checks++; if (pe_cnt - p0 !== 0) begin errors++; $display("FAIL parity_good_flag: got %0d expected 0", pe_cnt - p0); end
        v0 = valid_cycles; p0 = pe_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(20);
        checks++; if (pe_cnt - p0 !== 1) begin errors++; $display("FAIL parity_bad_flag: got %0d expected 1", pe_cnt - p0); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL parity_bad_valid: got %0d expected 0", valid_cycles - v0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
